fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end that drives the instruction-side SRAM-like request channel and feeds the decode stage. It generates the PC sequence (sequential, branch redirect, exception/ERET redirect) and issues one instruction request per decode slot. It presents {valid, pc, cancelled, exc} to decode using the same handshake decode consumes. Instruction data (`inst_rdata`/`inst_data_ok`) goes straight to decode; this block never samples it.

## Interface
- `RESET_PC`, 32'hbfc00000, first fetch address after reset.
- `clk` in 1: clock.
- `resetn` in 1: reset. One clock; reset is synchronous and active-low.
- `inst_req` out 1: request valid.
- `inst_addr` out 32: request address.
- `inst_addr_ok` in 1: address accepted this cycle.
- `br_valid_i` in 1: branch/jump redirect from ex. Ex asserts it only after the delay slot has been handed to decode.
- `br_target_i` in 32: branch target.
- `redir_valid_i` in 1: exception/ERET redirect from commit.
- `redir_pc_i` in 32: redirect target.
- `ready_i` in 1: decode accepts the slot (decode `done_o && ready_i`).
- `valid_o` out 1: slot holds an instruction.
- `pc_o` out 32: slot PC.
- `cancelled_o` out 1: slot is wrong-path; decode drops it after its data returns.
- `exc_o` out 1: fetch exception.
- `exc_miss_o` out 1: tied 0.
- `exccode_o` out 5: 5'h04 (AdEL) when `exc_o`.
- `perfcnt_fetch_waitaddr` out 32, `perfcnt_fetch_cancel` out 32: performance counters.

## Operation
- Registers: `fpc` (next address to request), slot {`pc`, `cancel`, `exc`}, state.
- Next-target priority: `redir_valid_i` > `br_valid_i` > `fpc`.
- States:
  - S_REQ: `inst_req=1`, `inst_addr` = next-target.
    - If `next-target[1:0]!=0`: no request; load slot with exc=1 and go S_EXC.
    - On `inst_addr_ok`: load slot pc, `fpc <= pc+4`, go S_OUT.
  - S_OUT: `valid_o=1`. On `ready_i`, issue the next request in the same cycle: `inst_req=1`, address = next-target (back-to-back).
    - `ready_i && inst_addr_ok`: stay in S_OUT with the new slot.
    - `ready_i && !inst_addr_ok`: go S_REQ.
    - Misaligned next-target: go S_EXC as above.
  - S_EXC: `valid_o=1`, `exc_o=1`, no request. On `ready_i`, go S_HALT.
  - S_HALT: `valid_o=0`, no request until `redir_valid_i`, then S_REQ with `fpc=redir_pc_i`.
- Redirects (any state):
  - `fpc` takes the target.
  - Current slot gets `cancel=1`; `cancelled_o` is combinationally set in the redirect cycle too.
  - A redirect in S_REQ before acceptance changes `inst_addr` directly; no cancel.
  - Redirect in the same cycle as `inst_addr_ok` in S_REQ: the accepted slot is marked cancelled and `fpc` = target.
  - In S_OUT with `ready_i`, the redirect cycle's new request uses the target.
  - `br_valid_i` is ignored in S_HALT.
- Sequential PC arithmetic is 32-bit modulo; 32'hfffffffc+4 wraps to 0.

## Timing
- Reset values: state S_REQ, `fpc=RESET_PC`, `valid_o=0`, `pc_o=0`, `cancelled_o=0`, `exc_o=0`, `exccode_o=0`, counters 0. `inst_req=1` in the first cycle after reset.
- `valid_o` rises the cycle after `inst_addr_ok`. Decode may see `inst_data_ok` that same cycle or later.
- Only one request is outstanding per slot; the next is issued no earlier than the `ready_i` cycle. Peak throughput is 1 instruction/cycle.
- `inst_req`/`inst_addr` are combinational from `ready_i`, redirect inputs and state. All other outputs are registered except `cancelled_o`'s redirect term.
- Reset mid-operation abandons in-flight requests; the memory side resets together with this block.

## Configuration
- `FETCH_PERFCNT_EN` defined:
  - `perfcnt_fetch_waitaddr` increments each cycle `inst_req && !inst_addr_ok`.
  - `perfcnt_fetch_cancel` increments on each `ready_i` with `cancelled_o=1`.
  - Both wrap modulo 2^32.
- Undefined: both ports are driven to constant 0 and no counter logic is built.

## Test plan
- Reset, `inst_addr_ok` always 1, `ready_i` always 1 -> `inst_addr` 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; `valid_o` high from cycle 2.
- `inst_addr_ok` delayed 3 cycles -> `inst_addr` held at 0xbfc00000 with `inst_req` high for 4 cycles. With `FETCH_PERFCNT_EN`, `perfcnt_fetch_waitaddr`=3.
- Slot pc 0x100 in S_OUT, `br_valid_i` with target 0x200 plus `ready_i` -> `cancelled_o=1` on the handoff, same-cycle `inst_addr`=0x200.
- `br_valid_i` and `redir_valid_i` in the same cycle (0x200 / 0x80000180) -> next request to 0x80000180.
- `redir_pc_i`=0x102 -> no request, `valid_o=1`, `exc_o=1`, `exccode_o`=5'h04. After `ready_i`, `inst_req` stays 0 until `redir_valid_i` to 0x80000180, then a request to 0x80000180.
- `resetn` low while waiting for `inst_addr_ok` -> next cycle `valid_o=0`, `inst_addr`=0xbfc00000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC sequencing, SRAM-like request issue, single decode slot.
// Latency: slot valid the cycle after inst_addr_ok; back-to-back issue gives 1 instr/cycle.
// Backpressure: next request only issues in the cycle decode takes the slot (ready_i).
// Optional feature: define FETCH_PERFCNT_EN to build the wait/cancel performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        br_valid_i,
    input  logic [31:0] br_target_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_fetch_waitaddr,
    output logic [31:0] perfcnt_fetch_cancel
);

    typedef enum logic [1:0] {S_REQ, S_OUT, S_EXC, S_HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fpc;
    logic [31:0] fpc_nxt;
    logic [31:0] slot_pc;
    logic        slot_cancel;
    logic [31:0] next_target;
    logic        br_take;
    logic        redir_any;
    logic        misaligned;
    logic        load_slot;
    logic        load_cancel;
    logic        slot_vld;

    // Pick the address for the next request: exception redirect beats branch beats sequential.
    always_comb begin
        br_take   = br_valid_i && (state != S_HALT);
        redir_any = redir_valid_i || br_take;
        if (redir_valid_i) begin
            next_target = redir_pc_i;
        end else if (br_take) begin
            next_target = br_target_i;
        end else begin
            next_target = fpc;
        end
        misaligned = (next_target[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus fetch-PC and slot-load decisions.
    always_comb begin
        state_nxt   = state;
        fpc_nxt     = next_target;
        load_slot   = 1'b0;
        load_cancel = 1'b0;
        case (state)
            S_REQ: begin
                if (misaligned) begin
                    state_nxt = S_EXC;
                    load_slot = 1'b1;
                end else if (inst_addr_ok) begin
                    // A redirect racing the acceptance leaves the slot wrong-path and refetches the target.
                    state_nxt   = S_OUT;
                    load_slot   = 1'b1;
                    load_cancel = redir_any;
                    fpc_nxt     = redir_any ? next_target : next_target + 32'd4;
                end
            end
            S_OUT: begin
                if (ready_i) begin
                    if (misaligned) begin
                        state_nxt = S_EXC;
                        load_slot = 1'b1;
                    end else if (inst_addr_ok) begin
                        load_slot = 1'b1;
                        fpc_nxt   = next_target + 32'd4;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_EXC: begin
                if (ready_i) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (redir_valid_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Output decode: request is combinational, slot fields come from registers.
    always_comb begin
        slot_vld    = (state == S_OUT) || (state == S_EXC);
        inst_req    = ((state == S_REQ) || ((state == S_OUT) && ready_i)) && !misaligned;
        inst_addr   = next_target;
        valid_o     = slot_vld;
        pc_o        = slot_pc;
        exc_o       = (state == S_EXC);
        exccode_o   = (state == S_EXC) ? 5'h04 : 5'h00;
        exc_miss_o  = 1'b0;
        cancelled_o = slot_vld && (slot_cancel || redir_any);
    end

    // Fetch PC and slot contents.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fpc         <= RESET_PC;
            slot_pc     <= 32'h0;
            slot_cancel <= 1'b0;
        end else begin
            fpc <= fpc_nxt;
            if (load_slot) begin
                slot_pc     <= next_target;
                slot_cancel <= load_cancel;
            end else if (slot_vld && ready_i) begin
                slot_cancel <= 1'b0;
            end else if (slot_vld && redir_any) begin
                slot_cancel <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERFCNT_EN
    logic [31:0] cnt_waitaddr;
    logic [31:0] cnt_cancel;

    // Count cycles stalled on address acceptance and wrong-path slots handed to decode.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_waitaddr <= 32'h0;
            cnt_cancel   <= 32'h0;
        end else begin
            if (inst_req && !inst_addr_ok) begin
                cnt_waitaddr <= cnt_waitaddr + 32'd1;
            end
            if (ready_i && cancelled_o) begin
                cnt_cancel <= cnt_cancel + 32'd1;
            end
        end
    end

    assign perfcnt_fetch_waitaddr = cnt_waitaddr;
    assign perfcnt_fetch_cancel   = cnt_cancel;
`else
    assign perfcnt_fetch_waitaddr = 32'h0;
    assign perfcnt_fetch_cancel   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, streaming, stalls, redirects, exceptions.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
// Counter expectations follow whether FETCH_PERFCNT_EN is defined.
module tb_fetch_stage;

`ifdef FETCH_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        br_valid_i;
    logic [31:0] br_target_i;
    logic        redir_valid_i;
    logic [31:0] redir_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_fetch_waitaddr;
    logic [31:0] perfcnt_fetch_cancel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .inst_req               (inst_req),
        .inst_addr              (inst_addr),
        .inst_addr_ok           (inst_addr_ok),
        .br_valid_i             (br_valid_i),
        .br_target_i            (br_target_i),
        .redir_valid_i          (redir_valid_i),
        .redir_pc_i             (redir_pc_i),
        .ready_i                (ready_i),
        .valid_o                (valid_o),
        .pc_o                   (pc_o),
        .cancelled_o            (cancelled_o),
        .exc_o                  (exc_o),
        .exc_miss_o             (exc_miss_o),
        .exccode_o              (exccode_o),
        .perfcnt_fetch_waitaddr (perfcnt_fetch_waitaddr),
        .perfcnt_fetch_cancel   (perfcnt_fetch_cancel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic ok, input logic rdy);
        next_cyc();
        resetn        = 1'b0;
        inst_addr_ok  = ok;
        ready_i       = rdy;
        br_valid_i    = 1'b0;
        redir_valid_i = 1'b0;
        next_cyc();
        resetn = 1'b1;
    endtask

    initial begin
        resetn        = 1'b0;
        inst_addr_ok  = 1'b1;
        ready_i       = 1'b1;
        br_valid_i    = 1'b0;
        br_target_i   = 32'h0;
        redir_valid_i = 1'b0;
        redir_pc_i    = 32'h0;

        // Reset state
        next_cyc();
        smp();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_cancel", 32'(cancelled_o), 32'd0);
        chk("rst_exc", 32'(exc_o), 32'd0);
        chk("rst_exccode", 32'(exccode_o), 32'd0);
        chk("rst_excmiss", 32'(exc_miss_o), 32'd0);
        chk("rst_pc_wait", perfcnt_fetch_waitaddr, 32'h0);
        chk("rst_pc_cancel", perfcnt_fetch_cancel, 32'h0);

        // Streaming with addr_ok and ready always high
        next_cyc();
        resetn = 1'b1;
        smp();
        chk("s1_req", 32'(inst_req), 32'd1);
        chk("s1_addr", inst_addr, 32'hbfc00000);
        chk("s1_valid", 32'(valid_o), 32'd0);
        next_cyc();
        smp();
        chk("s2_valid", 32'(valid_o), 32'd1);
        chk("s2_pc", pc_o, 32'hbfc00000);
        chk("s2_addr", inst_addr, 32'hbfc00004);
        next_cyc();
        smp();
        chk("s3_pc", pc_o, 32'hbfc00004);
        chk("s3_addr", inst_addr, 32'hbfc00008);

        // Address acceptance delayed three cycles
        apply_reset(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("w_req", 32'(inst_req), 32'd1);
            chk("w_addr", inst_addr, 32'hbfc00000);
            chk("w_valid", 32'(valid_o), 32'd0);
            next_cyc();
        end
        inst_addr_ok = 1'b1;
        smp();
        chk("w4_addr", inst_addr, 32'hbfc00000);
        next_cyc();
        smp();
        chk("w5_valid", 32'(valid_o), 32'd1);
        chk("w5_pc", pc_o, 32'hbfc00000);
        chk("w5_perf_wait", perfcnt_fetch_waitaddr, PERF ? 32'd3 : 32'd0);

        // Branch redirects in S_OUT, with and without ready
        apply_reset(1'b1, 1'b1);
        next_cyc();
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'h100;
        smp();
        chk("r1_cancel", 32'(cancelled_o), 32'd1);
        chk("r1_addr", inst_addr, 32'h100);
        next_cyc();
        redir_valid_i = 1'b0;
        br_valid_i    = 1'b1;
        br_target_i   = 32'h200;
        smp();
        chk("b1_pc", pc_o, 32'h100);
        chk("b1_cancel", 32'(cancelled_o), 32'd1);
        chk("b1_req", 32'(inst_req), 32'd1);
        chk("b1_addr", inst_addr, 32'h200);
        next_cyc();
        br_valid_i = 1'b0;
        smp();
        chk("b2_pc", pc_o, 32'h200);
        chk("b2_cancel", 32'(cancelled_o), 32'd0);
        chk("b2_addr", inst_addr, 32'h204);
        next_cyc();
        ready_i     = 1'b0;
        br_valid_i  = 1'b1;
        br_target_i = 32'h300;
        smp();
        chk("b3_pc", pc_o, 32'h204);
        chk("b3_cancel", 32'(cancelled_o), 32'd1);
        chk("b3_req", 32'(inst_req), 32'd0);
        next_cyc();
        br_valid_i = 1'b0;
        smp();
        chk("b4_pc", pc_o, 32'h204);
        chk("b4_cancel", 32'(cancelled_o), 32'd1);
        chk("b4_addr", inst_addr, 32'h300);
        chk("b4_req", 32'(inst_req), 32'd0);
        next_cyc();
        ready_i = 1'b1;
        smp();
        chk("b5_cancel", 32'(cancelled_o), 32'd1);
        chk("b5_req", 32'(inst_req), 32'd1);
        chk("b5_addr", inst_addr, 32'h300);

        // Branch and exception redirect together: exception target wins
        next_cyc();
        br_valid_i    = 1'b1;
        br_target_i   = 32'h200;
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'h80000180;
        smp();
        chk("p1_pc", pc_o, 32'h300);
        chk("p1_perf_cancel", perfcnt_fetch_cancel, PERF ? 32'd3 : 32'd0);
        chk("p1_addr", inst_addr, 32'h80000180);
        chk("p1_cancel", 32'(cancelled_o), 32'd1);
        next_cyc();
        br_valid_i    = 1'b0;
        redir_valid_i = 1'b0;
        smp();
        chk("p2_pc", pc_o, 32'h80000180);
        chk("p2_cancel", 32'(cancelled_o), 32'd0);

        // Redirects in S_REQ: before acceptance, then racing acceptance
        apply_reset(1'b0, 1'b1);
        br_valid_i  = 1'b1;
        br_target_i = 32'h400;
        smp();
        chk("q1_addr", inst_addr, 32'h400);
        chk("q1_req", 32'(inst_req), 32'd1);
        chk("q1_cancel", 32'(cancelled_o), 32'd0);
        next_cyc();
        br_valid_i    = 1'b0;
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'h500;
        inst_addr_ok  = 1'b1;
        smp();
        chk("q2_addr", inst_addr, 32'h500);
        next_cyc();
        redir_valid_i = 1'b0;
        smp();
        chk("q3_valid", 32'(valid_o), 32'd1);
        chk("q3_pc", pc_o, 32'h500);
        chk("q3_cancel", 32'(cancelled_o), 32'd1);
        chk("q3_addr", inst_addr, 32'h500);
        next_cyc();
        smp();
        chk("q4_cancel", 32'(cancelled_o), 32'd0);
        chk("q4_addr", inst_addr, 32'h504);

        // Misaligned redirect target: exception slot, halt, recovery
        next_cyc();
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'h102;
        smp();
        chk("e1_req", 32'(inst_req), 32'd0);
        chk("e1_cancel", 32'(cancelled_o), 32'd1);
        next_cyc();
        redir_valid_i = 1'b0;
        smp();
        chk("e2_valid", 32'(valid_o), 32'd1);
        chk("e2_exc", 32'(exc_o), 32'd1);
        chk("e2_exccode", 32'(exccode_o), 32'h04);
        chk("e2_pc", pc_o, 32'h102);
        chk("e2_req", 32'(inst_req), 32'd0);
        next_cyc();
        br_valid_i  = 1'b1;
        br_target_i = 32'h600;
        smp();
        chk("e3_valid", 32'(valid_o), 32'd0);
        chk("e3_exc", 32'(exc_o), 32'd0);
        chk("e3_exccode", 32'(exccode_o), 32'h0);
        chk("e3_req", 32'(inst_req), 32'd0);
        next_cyc();
        br_valid_i    = 1'b0;
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'h80000180;
        smp();
        chk("e4_req", 32'(inst_req), 32'd0);
        next_cyc();
        redir_valid_i = 1'b0;
        smp();
        chk("e5_req", 32'(inst_req), 32'd1);
        chk("e5_addr", inst_addr, 32'h80000180);
        chk("e5_valid", 32'(valid_o), 32'd0);

        // Sequential PC wraps at the top of the address space
        next_cyc();
        redir_valid_i = 1'b1;
        redir_pc_i    = 32'hfffffffc;
        smp();
        chk("x1_pc", pc_o, 32'h80000180);
        chk("x1_addr", inst_addr, 32'hfffffffc);
        next_cyc();
        redir_valid_i = 1'b0;
        inst_addr_ok  = 1'b0;
        smp();
        chk("x2_pc", pc_o, 32'hfffffffc);
        chk("x2_addr", inst_addr, 32'h0);
        chk("x2_req", 32'(inst_req), 32'd1);
        next_cyc();
        smp();
        chk("x3_valid", 32'(valid_o), 32'd0);
        chk("x3_addr", inst_addr, 32'h0);

        // Reset while waiting for address acceptance
        next_cyc();
        resetn = 1'b0;
        smp();
        next_cyc();
        resetn = 1'b1;
        smp();
        chk("m_valid", 32'(valid_o), 32'd0);
        chk("m_req", 32'(inst_req), 32'd1);
        chk("m_addr", inst_addr, 32'hbfc00000);
        chk("m_pc", pc_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
